s2_s3_pipe_reg: RTL and testbench

//   Pipeline register between stage 2 (decode/execute) and stage 3 (memory/writeback) of the 3-stage core.

---
 rtl/s2_s3_pipe_reg.sv | 154 +++++++++++++++
 tb/tb_s2_s3_pipe_reg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/s2_s3_pipe_reg.sv
// s2_s3_pipe_reg: pipeline register between stage 2 (decode/execute) and
// stage 3 (memory/writeback) of the 3-stage core.
//   - Captures the s2 bundle every unstalled edge (1-cycle latency).
//   - When the instruction in s3 redirects the PC, the next bundle is killed:
//     a bubble (NOP_INSN, valid_s3=0) is loaded, and flush_s1_s2 tells the
//     s1->s2 register to load a bubble on the same edge.
//   - Owns the tohost CSR, written by csrrw/csrrwi to CSR_TOHOST on retire.
//   - Optional cycle/instret counters, enabled by defining
//     S2S3_PERF_COUNTERS_EN; otherwise both outputs are tied to zero.
// Ports:
//   clk, rst              core clock, asynchronous active-high reset
//   stall                 hold all state this cycle
//   instruction_s2, pc_s2, alu_s2, rs2_data_s2, csr_data_s2   s2 bundle in
//   pc_sel_s3             s3 PC select (1 = redirect)
//   instruction_s3, pc_s3, alu_s3, rs2_data_s3, valid_s3       s3 bundle out
//   flush_s1_s2           combinational flush request for the s1->s2 register
//   csr_tohost            tohost CSR value
//   cycle_cnt, instret_cnt performance counters (zero when disabled)
module s2_s3_pipe_reg #(
  parameter logic [31:0] RESET_PC   = 32'h4000_0000,
  parameter logic [31:0] NOP_INSN   = 32'h0000_0013,
  parameter logic [11:0] CSR_TOHOST = 12'h51E
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] instruction_s2,
  input  logic [31:0] pc_s2,
  input  logic [31:0] alu_s2,
  input  logic [31:0] rs2_data_s2,
  input  logic [31:0] csr_data_s2,
  input  logic [1:0]  pc_sel_s3,
  output logic [31:0] instruction_s3,
  output logic [31:0] pc_s3,
  output logic [31:0] alu_s3,
  output logic [31:0] rs2_data_s3,
  output logic        valid_s3,
  output logic        flush_s1_s2,
  output logic [31:0] csr_tohost,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  logic [31:0] instruction_q, instruction_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] rs2_data_q, rs2_data_d;
  logic [31:0] csr_q, csr_d;
  logic        valid_q, valid_d;
  logic [31:0] tohost_q, tohost_d;

  logic redirect;
  logic retire;
  logic is_csr_tohost;

  // A bubble carrying pc_sel=1 is not a real branch, so it never redirects.
  assign redirect    = valid_q & (pc_sel_s3 == 2'd1);
  assign flush_s1_s2 = redirect & ~stall;
  assign retire      = valid_q & ~stall;

  assign is_csr_tohost = (instruction_q[6:2] == 5'b11100) &&
                         (instruction_q[31:20] == CSR_TOHOST);

  always_comb begin
    instruction_d = instruction_q;
    pc_d          = pc_q;
    alu_d         = alu_q;
    rs2_data_d    = rs2_data_q;
    csr_d         = csr_q;
    valid_d       = valid_q;
    if (!stall) begin
      pc_d       = pc_s2;
      alu_d      = alu_s2;
      rs2_data_d = rs2_data_s2;
      csr_d      = csr_data_s2;
      if (redirect) begin
        // Wrong-path instruction: keep its side-band data, kill the insn.
        instruction_d = NOP_INSN;
        valid_d       = 1'b0;
      end else begin
        instruction_d = instruction_s2;
        valid_d       = 1'b1;
      end
    end
  end

  // tohost is written on the edge that retires the CSR instruction.
  always_comb begin
    tohost_d = tohost_q;
    if (retire && is_csr_tohost) begin
      case (instruction_q[14:12])
        3'b001:  tohost_d = csr_q;
        3'b101:  tohost_d = {27'b0, instruction_q[19:15]};
        default: tohost_d = tohost_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction_q <= NOP_INSN;
      pc_q          <= RESET_PC;
      alu_q         <= 32'h0;
      rs2_data_q    <= 32'h0;
      csr_q         <= 32'h0;
      valid_q       <= 1'b0;
      tohost_q      <= 32'h0;
    end else begin
      instruction_q <= instruction_d;
      pc_q          <= pc_d;
      alu_q         <= alu_d;
      rs2_data_q    <= rs2_data_d;
      csr_q         <= csr_d;
      valid_q       <= valid_d;
      tohost_q      <= tohost_d;
    end
  end

  assign instruction_s3 = instruction_q;
  assign pc_s3          = pc_q;
  assign alu_s3         = alu_q;
  assign rs2_data_s3    = rs2_data_q;
  assign valid_s3       = valid_q;
  assign csr_tohost     = tohost_q;

`ifdef S2S3_PERF_COUNTERS_EN
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] instret_q, instret_d;

  // Both counters wrap naturally at 32 bits; cycle counts stalled edges too.
  always_comb begin
    cycle_d   = cycle_q + 32'd1;
    instret_d = instret_q;
    if (retire) instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q   <= 32'h0;
      instret_q <= 32'h0;
    end else begin
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`else
  assign cycle_cnt   = 32'h0;
  assign instret_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_s2_s3_pipe_reg.sv
module tb_s2_s3_pipe_reg;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] ADDI  = 32'h0010_0093; // addi x1,x0,1
  localparam logic [31:0] ADD   = 32'h0020_80B3; // add  x1,x1,x2
  localparam logic [31:0] BEQ   = 32'h0000_0463; // beq  x0,x0,8
  localparam logic [31:0] WRONG = 32'h0030_0193; // addi x3,x0,3
  localparam logic [31:0] CSRW  = 32'h51E0_9073; // csrrw x0,0x51E,x1
  localparam logic [31:0] CSRWI = 32'h51E2_D073; // csrrwi x0,0x51E,5
  localparam logic [31:0] CSRWX = 32'h51F0_9073; // csrrw x0,0x51F,x1

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] instruction_s2 = 32'h0;
  logic [31:0] pc_s2 = 32'h0;
  logic [31:0] alu_s2 = 32'h0;
  logic [31:0] rs2_data_s2 = 32'h0;
  logic [31:0] csr_data_s2 = 32'h0;
  logic [1:0]  pc_sel_s3 = 2'd0;
  logic [31:0] instruction_s3, pc_s3, alu_s3, rs2_data_s3;
  logic        valid_s3, flush_s1_s2;
  logic [31:0] csr_tohost, cycle_cnt, instret_cnt;

  int n_vec = 0;
  int n_err = 0;

  s2_s3_pipe_reg dut (
    .clk(clk), .rst(rst), .stall(stall),
    .instruction_s2(instruction_s2), .pc_s2(pc_s2), .alu_s2(alu_s2),
    .rs2_data_s2(rs2_data_s2), .csr_data_s2(csr_data_s2), .pc_sel_s3(pc_sel_s3),
    .instruction_s3(instruction_s3), .pc_s3(pc_s3), .alu_s3(alu_s3),
    .rs2_data_s3(rs2_data_s3), .valid_s3(valid_s3), .flush_s1_s2(flush_s1_s2),
    .csr_tohost(csr_tohost), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] insn, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [31:0] csr);
    instruction_s2 = insn;
    pc_s2          = pc;
    alu_s2         = alu;
    rs2_data_s2    = rs2;
    csr_data_s2    = csr;
  endtask

  initial begin
    // Power-on reset.
    #2 rst = 1'b1;
    #1;
    check("rst_insn", instruction_s3, NOP);
    check("rst_pc", pc_s3, 32'h4000_0000);
    check("rst_valid", {31'b0, valid_s3}, 32'd0);
    check("rst_tohost", csr_tohost, 32'h0);
    step();
    rst = 1'b0;

    // Back-to-back instructions, one-edge latency.
    drive(ADDI, 32'h4000_0000, 32'h1, 32'h0, 32'h0);
    step();
    check("addi_insn", instruction_s3, ADDI);
    check("addi_pc", pc_s3, 32'h4000_0000);
    check("addi_valid", {31'b0, valid_s3}, 32'd1);
    drive(ADD, 32'h4000_0004, 32'h2, 32'h55, 32'h0);
    step();
    check("add_insn", instruction_s3, ADD);
    check("add_pc", pc_s3, 32'h4000_0004);
    check("add_alu", alu_s3, 32'h2);
    check("add_rs2", rs2_data_s3, 32'h55);

    // Unstalled redirect.
    drive(BEQ, 32'h4000_0008, 32'h0, 32'h0, 32'h0);
    step();
    check("beq_insn", instruction_s3, BEQ);
    drive(WRONG, 32'h4000_000C, 32'h3, 32'h0, 32'h0);
    pc_sel_s3 = 2'd1;
    #1;
    check("redir_flush", {31'b0, flush_s1_s2}, 32'd1);
    step();
    check("bubble_insn", instruction_s3, NOP);
    check("bubble_valid", {31'b0, valid_s3}, 32'd0);
    check("bubble_pc", pc_s3, 32'h4000_000C);
    check("bubble_noflush", {31'b0, flush_s1_s2}, 32'd0);
    pc_sel_s3 = 2'd0;

    // Redirect held off by a 3-cycle stall.
    drive(BEQ, 32'h4000_0010, 32'h0, 32'h0, 32'h0);
    step();
    check("beq2_valid", {31'b0, valid_s3}, 32'd1);
    drive(WRONG, 32'h4000_0014, 32'h3, 32'h0, 32'h0);
    pc_sel_s3 = 2'd1;
    stall     = 1'b1;
    #1;
    check("stall_flush", {31'b0, flush_s1_s2}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_insn", instruction_s3, BEQ);
      check("stall_pc", pc_s3, 32'h4000_0010);
      check("stall_valid", {31'b0, valid_s3}, 32'd1);
      check("stall_flush_hold", {31'b0, flush_s1_s2}, 32'd0);
    end
    stall = 1'b0;
    #1;
    check("unstall_flush", {31'b0, flush_s1_s2}, 32'd1);
    step();
    check("unstall_insn", instruction_s3, NOP);
    check("unstall_valid", {31'b0, valid_s3}, 32'd0);
    pc_sel_s3 = 2'd0;

    // tohost CSR writes.
    drive(CSRW, 32'h4000_0020, 32'h0, 32'h0, 32'hDEAD_BEEF);
    step();
    check("csrw_pending", csr_tohost, 32'h0);
    drive(CSRWI, 32'h4000_0024, 32'h0, 32'h0, 32'h1234_5678);
    step();
    check("csrw_tohost", csr_tohost, 32'hDEAD_BEEF);
    drive(CSRWX, 32'h4000_0028, 32'h0, 32'h0, 32'hCAFE_F00D);
    step();
    check("csrwi_tohost", csr_tohost, 32'h0000_0005);
    drive(NOP, 32'h4000_002C, 32'h0, 32'h0, 32'h0);
    step();
    check("csrw51f_tohost", csr_tohost, 32'h0000_0005);
    check("pre_rst_valid", {31'b0, valid_s3}, 32'd1);

    // Mid-cycle asynchronous reset, no clock edge needed.
    #3 rst = 1'b1;
    #1;
    check("arst_pc", pc_s3, 32'h4000_0000);
    check("arst_valid", {31'b0, valid_s3}, 32'd0);
    check("arst_insn", instruction_s3, NOP);
    check("arst_alu", alu_s3, 32'h0);
    check("arst_tohost", csr_tohost, 32'h0);
    step();
    rst = 1'b0;

    // Counter window: 10 edges, 6 retires, 2 stalls, 2 bubbles.
    drive(ADDI, 32'h4000_0000, 32'h1, 32'h0, 32'h0);
    step();                      // edge 1: bubble in s3
    step(); step(); step();      // edges 2-4: retire
    stall = 1'b1;
    step(); step();              // edges 5-6: stalled
    stall = 1'b0;
    pc_sel_s3 = 2'd1;
    step();                      // edge 7: retire + redirect
    pc_sel_s3 = 2'd0;
    step();                      // edge 8: bubble in s3
    step(); step();              // edges 9-10: retire
`ifdef S2S3_PERF_COUNTERS_EN
    check("cycle_cnt", cycle_cnt, 32'd10);
    check("instret_cnt", instret_cnt, 32'd6);
`else
    check("cycle_cnt_off", cycle_cnt, 32'd0);
    check("instret_cnt_off", instret_cnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
